mc_decode_ctrl: RTL and testbench
=================================

MC_DECODE_CTRL -- requirements
Module: mc_decode_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4: execute cycles for MUL/UMULL/SMULL, legal range 1..16.
REQ-002 SHALL have parameter DIV_LAT, default 32: execute cycles for DIV, legal range 1..64.
REQ-003 SHALL have the following ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low.
- Instr  in  32  instruction register contents.
- IRWrite, NextPC, RegW, MemW, PCS, AdrSrc  out  1  datapath strobes/selects.
- ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2  datapath selects.
- ALUControl  out  4  ALU operation.
- FlagW  out  2  flag write enables {NZ, CV}.
- WA3Sel  out  1  write address: 0 = Instr[15:12], 1 = Instr[19:16].
- HiSel  out  1  selects upper 32 bits of the 64-bit product.
- LongBusy  out  1  high during a multi-cycle execute.

Function
REQ-004 SHALL decode Op=Instr[27:26], Funct=Instr[25:20]; is_mul = (Op==00 & ~Funct[5] & Instr[7:4]==1001); is_long = is_mul & Instr[23]; signed = Instr[22]; is_div = (Op==00 & ~is_mul & Funct[4:1]==1011).
REQ-005 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, LONGEX, LONGWB0, LONGWB1.
REQ-006 Transitions:
- FETCH->DECODE.
- DECODE->LONGEX if is_mul|is_div.
- DECODE->MEMADR if Op=01.
- DECODE->EXECI if Op=00 & Funct[5].
- DECODE->EXECR if Op=00 & ~Funct[5].
- DECODE->BRANCH if Op=10.
- DECODE->FETCH if Op=11 (no writes).
- MEMADR->MEMRD if Funct[0], else ->MEMWR.
- MEMRD->MEMWB.
- EXECR/EXECI->ALUWB.
- LONGEX->LONGWB0 when count==0.
- LONGWB0->LONGWB1 if is_long, else ->FETCH.
- MEMWB, MEMWR, ALUWB, BRANCH, LONGWB1 -> FETCH.
REQ-007 State outputs (unlisted = 0):
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECR: ALUSrcB=00.
- EXECI: ALUSrcB=01.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, internal Branch=1.
- LONGEX: LongBusy=1.
- LONGWB0: RegW=1, WA3Sel = ~is_long.
- LONGWB1: RegW=1, WA3Sel=1, HiSel=1.
REQ-008 ALUControl in EXECR/EXECI/ALUWB/LONGEX/LONGWB* SHALL be:
- UMULL=0110, SMULL=1000, MUL=0100, DIV=0111.
- Otherwise by Funct[4:1]: 0100->0000, 0010->0001, 0000->0010, 1100->0011, 1010->0101, other->0000.
- All other states: 0000.
REQ-009 FlagW SHALL be {Funct[0], Funct[0] & ALUControl∈{0000,0001}} only in EXECR, EXECI and the final LONGEX cycle; 00 elsewhere.
REQ-010 ImmSrc=Op, RegSrc = {Op==01 & ~Funct[0], Op==10} combinationally, in all states.
REQ-011 Counter: on DECODE->LONGEX SHALL load (is_div ? DIV_LAT : MUL_LAT)-1; decrement each LONGEX cycle; LONGEX lasts exactly the selected latency (1 cycle when latency=1).
REQ-012 PCS = Branch | (RegW & selected write address==4'hF), evaluated in every state including LONGWB0/1.
REQ-013 Instr SHALL be sampled only via decode of the held instruction register; Instr changes outside FETCH are not permitted by the datapath and need no handling.

Reset
REQ-014 reset==0 at a clk edge SHALL force state=FETCH and count=0, aborting any state including mid-LONGEX.
REQ-015 While reset==0, IRWrite, NextPC, RegW, MemW, PCS, LongBusy, FlagW SHALL be 0; selects SHALL hold FETCH values.
REQ-016 First FETCH strobes SHALL appear in the first cycle after reset returns to 1.

Verification
REQ-017 ADD R1,R2,#5 (Op=00, Funct=101000) -> FETCH, DECODE, EXECI, ALUWB; ALUControl=0000; RegW=1 only in ALUWB; FlagW=00.
REQ-018 UMULL, MUL_LAT=4 (Instr[23]=1, [22]=0, [7:4]=1001) -> LongBusy high 4 cycles; ALUControl=0110; LONGWB0 WA3Sel=0/HiSel=0; LONGWB1 WA3Sel=1/HiSel=1; 8 cycles total.
REQ-019 SMULL with S=1, MUL_LAT=1 -> single LONGEX cycle; ALUControl=1000; FlagW=10 in that cycle.
REQ-020 DIV, DIV_LAT=32 -> LongBusy exactly 32 cycles; single writeback with WA3Sel=1; ALUControl=0111.
REQ-021 LDR Rd=15 -> PCS=1 in MEMWB only; Op=11 -> DECODE->FETCH with no RegW/MemW.
REQ-022 reset=0 on the 3rd LONGEX cycle -> next cycle state FETCH, LongBusy=0, no writeback ever issued.

Source files
------------

// File: rtl/mc_decode_ctrl.sv
// Multicycle ARM-style control unit: instruction decode plus a Moore FSM that
// sequences fetch/decode/memory/ALU/branch and multi-cycle multiply/divide.
module mc_decode_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   output logic        IRWrite,
   output logic        NextPC,
   output logic        RegW,
   output logic        MemW,
   output logic        PCS,
   output logic        AdrSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [3:0]  ALUControl,
   output logic [1:0]  FlagW,
   output logic        WA3Sel,
   output logic        HiSel,
   output logic        LongBusy
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
      ALUWB, BRANCH, LONGEX, LONGWB0, LONGWB1
   } state_t;

   localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

   state_t      state, state_next;
   logic [5:0]  count;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic        is_mul, is_long, is_signed, is_div;
   logic [3:0]  alu_dec;
   logic [1:0]  flag_dec;
   logic        branch;
   logic [3:0]  wa;
   logic        unused_instr;

   assign op        = Instr[27:26];
   assign funct     = Instr[25:20];
   assign is_mul    = (op == 2'b00) && !funct[5] && (Instr[7:4] == 4'b1001);
   assign is_long   = is_mul && Instr[23];
   assign is_signed = Instr[22];
   assign is_div    = (op == 2'b00) && !is_mul && (funct[4:1] == 4'b1011);
   assign unused_instr = ^{Instr[31:28], Instr[11:8], Instr[3:0]};

   always_comb begin
      alu_dec = 4'b0000;
      if (is_long)     alu_dec = is_signed ? 4'b1000 : 4'b0110;
      else if (is_mul) alu_dec = 4'b0100;
      else if (is_div) alu_dec = 4'b0111;
      else begin
         case (funct[4:1])
            4'b0100: alu_dec = 4'b0000;
            4'b0010: alu_dec = 4'b0001;
            4'b0000: alu_dec = 4'b0010;
            4'b1100: alu_dec = 4'b0011;
            4'b1010: alu_dec = 4'b0101;
            default: alu_dec = 4'b0000;
         endcase
      end
   end

   // C/V flags are only written by add/subtract
   assign flag_dec = {funct[0], funct[0] && (alu_dec == 4'b0000 || alu_dec == 4'b0001)};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= FETCH;
         count <= 6'd0;
      end else begin
         state <= state_next;
         if (state == DECODE && state_next == LONGEX)
            count <= is_div ? DIV_LOAD : MUL_LOAD;
         else if (state == LONGEX && count != 6'd0)
            count <= count - 6'd1;
      end
   end

   always_comb begin
      state_next = state;
      IRWrite    = 1'b0;
      NextPC     = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 4'b0000;
      FlagW      = 2'b00;
      WA3Sel     = 1'b0;
      HiSel      = 1'b0;
      LongBusy   = 1'b0;
      branch     = 1'b0;
      case (state)
         FETCH: begin
            IRWrite = 1'b1; NextPC = 1'b1;
            ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            state_next = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            if (is_mul || is_div) state_next = LONGEX;
            else begin
               case (op)
                  2'b01:   state_next = MEMADR;
                  2'b00:   state_next = funct[5] ? EXECI : EXECR;
                  2'b10:   state_next = BRANCH;
                  default: state_next = FETCH;
               endcase
            end
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            state_next = funct[0] ? MEMRD : MEMWR;
         end
         MEMRD:  begin AdrSrc = 1'b1; state_next = MEMWB; end
         MEMWB:  begin ResultSrc = 2'b01; RegW = 1'b1; state_next = FETCH; end
         MEMWR:  begin AdrSrc = 1'b1; MemW = 1'b1; state_next = FETCH; end
         EXECR: begin
            ALUSrcB = 2'b00; ALUControl = alu_dec; FlagW = flag_dec;
            state_next = ALUWB;
         end
         EXECI: begin
            ALUSrcB = 2'b01; ALUControl = alu_dec; FlagW = flag_dec;
            state_next = ALUWB;
         end
         ALUWB:  begin RegW = 1'b1; ALUControl = alu_dec; state_next = FETCH; end
         BRANCH: begin
            ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
            state_next = FETCH;
         end
         LONGEX: begin
            LongBusy = 1'b1; ALUControl = alu_dec;
            if (count == 6'd0) begin
               FlagW = flag_dec;
               state_next = LONGWB0;
            end
         end
         LONGWB0: begin
            RegW = 1'b1; WA3Sel = !is_long; ALUControl = alu_dec;
            state_next = is_long ? LONGWB1 : FETCH;
         end
         LONGWB1: begin
            RegW = 1'b1; WA3Sel = 1'b1; HiSel = 1'b1; ALUControl = alu_dec;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase

      ImmSrc = op;
      RegSrc = {(op == 2'b01) && !funct[0], op == 2'b10};
      wa     = WA3Sel ? Instr[19:16] : Instr[15:12];
      PCS    = branch || (RegW && wa == 4'hF);

      // Strobes are held off and selects parked at FETCH values during reset
      if (!reset) begin
         IRWrite = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
         PCS = 1'b0; LongBusy = 1'b0; FlagW = 2'b00; AdrSrc = 1'b0;
         ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         ALUControl = 4'b0000; WA3Sel = 1'b0; HiSel = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_decode_ctrl.sv
// Directed bench for mc_decode_ctrl: per-cycle expected output vectors are
// queued as each instruction is applied and compared as the FSM steps.
module tb_mc_decode_ctrl;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                  S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                  S_LONGEX = 10, S_LONGWB0 = 11, S_LONGWB1 = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;

   logic        a_irw, a_npc, a_regw, a_memw, a_pcs, a_adr, a_wsel, a_hi, a_busy;
   logic [1:0]  a_sa, a_sb, a_rs, a_imm, a_rsrc, a_fw;
   logic [3:0]  a_alu;
   logic        b_irw, b_npc, b_regw, b_memw, b_pcs, b_adr, b_wsel, b_hi, b_busy;
   logic [1:0]  b_sa, b_sb, b_rs, b_imm, b_rsrc, b_fw;
   logic [3:0]  b_alu;
   logic [24:0] obs0, obs1;

   logic [24:0] exp_q[$];
   string       tag_q[$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   mc_decode_ctrl dut (
      .clk(clk), .reset(reset), .Instr(Instr),
      .IRWrite(a_irw), .NextPC(a_npc), .RegW(a_regw), .MemW(a_memw), .PCS(a_pcs),
      .AdrSrc(a_adr), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ResultSrc(a_rs),
      .ImmSrc(a_imm), .RegSrc(a_rsrc), .ALUControl(a_alu), .FlagW(a_fw),
      .WA3Sel(a_wsel), .HiSel(a_hi), .LongBusy(a_busy)
   );

   mc_decode_ctrl #(.MUL_LAT(1), .DIV_LAT(32)) dut1 (
      .clk(clk), .reset(reset), .Instr(Instr),
      .IRWrite(b_irw), .NextPC(b_npc), .RegW(b_regw), .MemW(b_memw), .PCS(b_pcs),
      .AdrSrc(b_adr), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ResultSrc(b_rs),
      .ImmSrc(b_imm), .RegSrc(b_rsrc), .ALUControl(b_alu), .FlagW(b_fw),
      .WA3Sel(b_wsel), .HiSel(b_hi), .LongBusy(b_busy)
   );

   assign obs0 = {a_irw, a_npc, a_regw, a_memw, a_pcs, a_adr, a_sa, a_sb, a_rs,
                  a_imm, a_rsrc, a_alu, a_fw, a_wsel, a_hi, a_busy};
   assign obs1 = {b_irw, b_npc, b_regw, b_memw, b_pcs, b_adr, b_sa, b_sb, b_rs,
                  b_imm, b_rsrc, b_alu, b_fw, b_wsel, b_hi, b_busy};

   // Expected outputs for one cycle spent in state st with instruction ins
   function automatic logic [24:0] exp_out(input int st, input logic [31:0] ins,
                                           input bit last, input bit rst);
      logic [1:0] op, sa, sb, rs, fw;
      logic [5:0] fn;
      logic [3:0] alu, ac;
      logic       mul, lng, dv, irw, npc, regw, memw, pcs, adr, wsel, hi, busy, br;
      op  = ins[27:26];
      fn  = ins[25:20];
      mul = (op == 2'b00) && !fn[5] && (ins[7:4] == 4'b1001);
      lng = mul && ins[23];
      dv  = (op == 2'b00) && !mul && (fn[4:1] == 4'b1011);
      if (lng)      alu = ins[22] ? 4'b1000 : 4'b0110;
      else if (mul) alu = 4'b0100;
      else if (dv)  alu = 4'b0111;
      else if (fn[4:1] == 4'b0010) alu = 4'b0001;
      else if (fn[4:1] == 4'b0000) alu = 4'b0010;
      else if (fn[4:1] == 4'b1100) alu = 4'b0011;
      else if (fn[4:1] == 4'b1010) alu = 4'b0101;
      else alu = 4'b0000;
      {irw, npc, regw, memw, adr, wsel, hi, busy, br} = '0;
      sa = 2'b00; sb = 2'b00; rs = 2'b00; fw = 2'b00; ac = 4'b0000;
      case (st)
         S_FETCH:   begin irw = 1; npc = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
         S_DECODE:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
         S_MEMADR:  sb = 2'b01;
         S_MEMRD:   adr = 1;
         S_MEMWB:   begin rs = 2'b01; regw = 1; end
         S_MEMWR:   begin adr = 1; memw = 1; end
         S_EXECR:   begin ac = alu; fw = {fn[0], fn[0] && alu[3:1] == 3'b000}; end
         S_EXECI:   begin sb = 2'b01; ac = alu; fw = {fn[0], fn[0] && alu[3:1] == 3'b000}; end
         S_ALUWB:   begin regw = 1; ac = alu; end
         S_BRANCH:  begin sb = 2'b01; rs = 2'b10; br = 1; end
         S_LONGEX:  begin
            busy = 1; ac = alu;
            if (last) fw = {fn[0], fn[0] && alu[3:1] == 3'b000};
         end
         S_LONGWB0: begin regw = 1; wsel = !lng; ac = alu; end
         S_LONGWB1: begin regw = 1; wsel = 1; hi = 1; ac = alu; end
         default:   ;
      endcase
      pcs = br || (regw && ((wsel ? ins[19:16] : ins[15:12]) == 4'hF));
      if (rst) begin
         {irw, npc, regw, memw, pcs, adr, wsel, hi, busy} = '0;
         sa = 2'b01; sb = 2'b10; rs = 2'b10; fw = 2'b00; ac = 4'b0000;
      end
      return {irw, npc, regw, memw, pcs, adr, sa, sb, rs, op,
              {(op == 2'b01) && !fn[0], op == 2'b10}, ac, fw, wsel, hi, busy};
   endfunction

   task automatic push(input int st, input bit last, input bit rst, input string tag);
      exp_q.push_back(exp_out(st, Instr, last, rst));
      tag_q.push_back(tag);
   endtask

   task automatic push_long(input int n, input bit ends, input string tag);
      for (int i = 0; i < n; i++) push(S_LONGEX, ends && (i == n - 1), 1'b0, tag);
   endtask

   task automatic step(input bit sel);
      logic [24:0] e, o;
      string       t;
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = sel ? obs1 : obs0;
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", t, o, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit sel);
      while (exp_q.size() > 0) step(sel);
   endtask

   initial begin
      reset = 1'b0;
      Instr = 32'hE000_0000;
      @(posedge clk);
      #1;
      push(S_FETCH, 0, 1, "reset_a");
      push(S_FETCH, 0, 1, "reset_b");
      drain(0);
      reset = 1'b1;

      // ADD R1,R2,#5
      Instr = 32'hE282_1005;
      push(S_FETCH, 0, 0, "add_fetch"); push(S_DECODE, 0, 0, "add_dec");
      push(S_EXECI, 0, 0, "add_exec");  push(S_ALUWB, 0, 0, "add_wb");
      drain(0);

      // SUBS R3,R4,R5
      Instr = 32'hE054_3005;
      push(S_FETCH, 0, 0, "subs_fetch"); push(S_DECODE, 0, 0, "subs_dec");
      push(S_EXECR, 0, 0, "subs_exec");  push(S_ALUWB, 0, 0, "subs_wb");
      drain(0);

      // UMULL RdLo=3 RdHi=4, four execute cycles
      Instr = 32'hE084_3291;
      push(S_FETCH, 0, 0, "umull_fetch"); push(S_DECODE, 0, 0, "umull_dec");
      push_long(4, 1, "umull_ex");
      push(S_LONGWB0, 0, 0, "umull_wb0"); push(S_LONGWB1, 0, 0, "umull_wb1");
      drain(0);

      // DIV R1, thirty-two execute cycles, single writeback to Instr[19:16]
      Instr = 32'hE161_2003;
      push(S_FETCH, 0, 0, "div_fetch"); push(S_DECODE, 0, 0, "div_dec");
      push_long(32, 1, "div_ex");
      push(S_LONGWB0, 0, 0, "div_wb0");
      drain(0);

      // MUL with Rd=15 raises PCS on its writeback
      Instr = 32'hE00F_0291;
      push(S_FETCH, 0, 0, "mul_fetch"); push(S_DECODE, 0, 0, "mul_dec");
      push_long(4, 1, "mul_ex");
      push(S_LONGWB0, 0, 0, "mul_wb0");
      drain(0);

      // LDR R15,[R1,#4]
      Instr = 32'hE591_F004;
      push(S_FETCH, 0, 0, "ldr_fetch"); push(S_DECODE, 0, 0, "ldr_dec");
      push(S_MEMADR, 0, 0, "ldr_adr");  push(S_MEMRD, 0, 0, "ldr_rd");
      push(S_MEMWB, 0, 0, "ldr_wb");
      drain(0);

      // STR R2,[R1,#4]
      Instr = 32'hE581_2004;
      push(S_FETCH, 0, 0, "str_fetch"); push(S_DECODE, 0, 0, "str_dec");
      push(S_MEMADR, 0, 0, "str_adr");  push(S_MEMWR, 0, 0, "str_wr");
      drain(0);

      // B +2
      Instr = 32'hEA00_0002;
      push(S_FETCH, 0, 0, "b_fetch"); push(S_DECODE, 0, 0, "b_dec");
      push(S_BRANCH, 0, 0, "b_branch");
      drain(0);

      // Op=11 goes straight back to FETCH with no writes
      Instr = 32'hEC00_0000;
      push(S_FETCH, 0, 0, "op11_fetch"); push(S_DECODE, 0, 0, "op11_dec");
      drain(0);

      // UMULL aborted by reset during its third execute cycle
      Instr = 32'hE084_3291;
      push(S_FETCH, 0, 0, "abort_fetch"); push(S_DECODE, 0, 0, "abort_dec");
      push_long(2, 0, "abort_ex");
      drain(0);
      reset = 1'b0;
      push(S_FETCH, 0, 1, "abort_rst");
      drain(0);
      reset = 1'b1;
      Instr = 32'hEC00_0000;
      push(S_FETCH, 0, 0, "abort_refetch"); push(S_DECODE, 0, 0, "abort_dec2");
      push(S_FETCH, 0, 0, "abort_fetch2");
      drain(0);

      // SMULL with S=1 on the single-cycle multiplier instance
      reset = 1'b0;
      Instr = 32'hE0D4_3291;
      push(S_FETCH, 0, 1, "smull_rst");
      drain(1);
      reset = 1'b1;
      push(S_FETCH, 0, 0, "smull_fetch"); push(S_DECODE, 0, 0, "smull_dec");
      push_long(1, 1, "smull_ex");
      push(S_LONGWB0, 0, 0, "smull_wb0"); push(S_LONGWB1, 0, 0, "smull_wb1");
      push(S_FETCH, 0, 0, "smull_next");
      drain(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
